// File: rtl/obstacle_field_gen_if.sv
// Control and draw bus between the game controller and obstacle_field_gen.
// The master drives the animation controls; the slave returns the field geometry and game events.
interface obstacle_field_gen_if #(
    parameter int unsigned N_OBS = 8,
    parameter int unsigned CW    = 12
);
    logic                  i_ani_stb;
    logic                  i_animate;
    logic                  i_pause;
    logic                  i_lose;
    logic                  i_done;
    logic [3:0]            i_speed;
    logic [N_OBS*CW-1:0]   o_x_l;
    logic [N_OBS*CW-1:0]   o_x_r;
    logic [N_OBS*CW-1:0]   o_y_t;
    logic [N_OBS*CW-1:0]   o_y_b;
    logic [N_OBS-1:0]      o_active;
    logic                  o_score;
    logic [7:0]            o_level;
    logic                  o_level_up;
    logic                  o_paused;
    logic                  o_field_empty;

    modport master (
        output i_ani_stb, i_animate, i_pause, i_lose, i_done, i_speed,
        input  o_x_l, o_x_r, o_y_t, o_y_b, o_active, o_score, o_level,
               o_level_up, o_paused, o_field_empty
    );

    modport slave (
        input  i_ani_stb, i_animate, i_pause, i_lose, i_done, i_speed,
        output o_x_l, o_x_r, o_y_t, o_y_b, o_active, o_score, o_level,
               o_level_up, o_paused, o_field_empty
    );
endinterface

// File: rtl/obstacle_field_gen.sv
// Scrolling obstacle field: N_OBS recycled slots with LFSR-chosen kinds, score/level events, per-slot rectangles.
// Optional: define LEVEL_SPEEDUP_EN to add (level-1)>>2 to the scroll speed, capped at 15.
module obstacle_field_gen #(
    parameter int unsigned N_OBS         = 8,
    parameter int unsigned CW            = 12,
    parameter int unsigned D_WIDTH       = 640,
    parameter int unsigned D_HEIGHT      = 480,
    parameter int unsigned H_WIDTH       = 20,
    parameter int unsigned HEIGHT_L      = 40,
    parameter int unsigned HEIGHT_H      = 400,
    parameter int unsigned SPACING       = 80,
    parameter int unsigned OBS_PER_LEVEL = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input logic               i_clk,
    input logic               i_rst,
    obstacle_field_gen_if.slave bus
);
    localparam int unsigned   CNT_W    = $clog2(OBS_PER_LEVEL + 1);
    localparam logic [CW-1:0] X_RCY    = CW'(D_WIDTH - H_WIDTH);
    localparam logic [CW-1:0] X_LEFT   = CW'(D_WIDTH + H_WIDTH);
    localparam logic [CW-1:0] X_WRAP   = CW'(N_OBS * SPACING);
    localparam logic [CW-1:0] DW       = CW'(D_WIDTH);
    localparam logic [CW-1:0] DH       = CW'(D_HEIGHT);
    localparam logic [CW-1:0] Y_LOW_T  = CW'(D_HEIGHT - HEIGHT_L);
    localparam logic [CW-1:0] Y_HIGH_B = CW'(HEIGHT_H);

    logic [CW-1:0]    x_q    [N_OBS];
    logic [1:0]       kind_q [N_OBS];
    logic [CW-1:0]    x_n    [N_OBS];
    logic [1:0]       kind_n [N_OBS];
    logic [7:0]       lfsr_q, lfsr_n;
    logic [7:0]       level_q, level_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             paused_q, pause_d_q;
    logic             move_c, found_c, score_c, level_up_c, all_empty_c;
    logic [3:0]       speed_c;
    logic [CW-1:0]    xl_c, xr_c;
    logic [N_OBS*CW-1:0] x_l_c, x_r_c, y_t_c, y_b_c;
    logic [N_OBS-1:0]    active_c;

    assign move_c = bus.i_ani_stb & bus.i_animate & ~paused_q & ~bus.i_lose;

`ifdef LEVEL_SPEEDUP_EN
    logic [8:0] spd_sum_c;
    assign spd_sum_c = 9'(bus.i_speed) + 9'(8'(level_q - 8'd1) >> 2);
    assign speed_c   = (spd_sum_c > 9'd15) ? 4'd15 : spd_sum_c[3:0];
`else
    assign speed_c = bus.i_speed;
`endif

    // Slot motion and recycling; the lowest recycling index owns the score event.
    always_comb begin
        lfsr_n     = lfsr_q;
        found_c    = 1'b0;
        score_c    = 1'b0;
        level_up_c = 1'b0;
        cnt_n      = cnt_q;
        level_n    = level_q;
        for (int unsigned i = 0; i < N_OBS; i++) begin
            x_n[i]    = x_q[i];
            kind_n[i] = kind_q[i];
            if (move_c) begin
                if (x_q[i] <= X_RCY) begin
                    x_n[i]    = x_q[i] + X_WRAP;
                    kind_n[i] = bus.i_done ? 2'b00 : lfsr_n[1:0];
                    lfsr_n    = {lfsr_n[6:0], lfsr_n[7] ^ lfsr_n[5] ^ lfsr_n[4] ^ lfsr_n[3]};
                    if (!found_c) begin
                        found_c = 1'b1;
                        score_c = (kind_q[i] != 2'b00);
                    end
                end else begin
                    x_n[i] = x_q[i] - CW'(speed_c);
                end
            end
        end
        if (score_c) begin
            if (cnt_q == CNT_W'(OBS_PER_LEVEL - 1)) begin
                cnt_n = '0;
                if (level_q != 8'hFF) begin
                    level_n    = level_q + 8'd1;
                    level_up_c = 1'b1;
                end
            end else begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end
    end

    // Screen rectangles; empty or fully off-right slots use the hidden encoding.
    always_comb begin
        xl_c        = '0;
        xr_c        = '0;
        x_l_c       = '0;
        x_r_c       = '0;
        y_t_c       = '0;
        y_b_c       = '0;
        active_c    = '0;
        all_empty_c = 1'b1;
        for (int unsigned i = 0; i < N_OBS; i++) begin
            xl_c = (x_q[i] <= X_LEFT) ? '0 : x_q[i] - X_LEFT;
            if (x_q[i] <= X_RCY)
                xr_c = '0;
            else if ((x_q[i] - X_RCY) > DW)
                xr_c = DW;
            else
                xr_c = x_q[i] - X_RCY;
            if (kind_q[i] != 2'b00)
                all_empty_c = 1'b0;
            if ((kind_q[i] == 2'b00) || (xl_c >= DW)) begin
                x_l_c[i*CW +: CW] = DW;
                y_t_c[i*CW +: CW] = DH;
            end else begin
                active_c[i]       = 1'b1;
                x_l_c[i*CW +: CW] = xl_c;
                x_r_c[i*CW +: CW] = xr_c;
                y_t_c[i*CW +: CW] = (kind_q[i] == 2'b10) ? '0 : Y_LOW_T;
                y_b_c[i*CW +: CW] = (kind_q[i] == 2'b10) ? Y_HIGH_B : DH;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N_OBS; i++) begin
                x_q[i]    <= CW'(2 * D_WIDTH + H_WIDTH + i * SPACING);
                kind_q[i] <= 2'b01;
            end
            lfsr_q            <= LFSR_SEED;
            level_q           <= 8'd1;
            cnt_q             <= '0;
            paused_q          <= 1'b0;
            pause_d_q         <= 1'b0;
            bus.o_x_l         <= {N_OBS{DW}};
            bus.o_x_r         <= '0;
            bus.o_y_t         <= {N_OBS{DH}};
            bus.o_y_b         <= '0;
            bus.o_active      <= '0;
            bus.o_score       <= 1'b0;
            bus.o_level_up    <= 1'b0;
            bus.o_field_empty <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_OBS; i++) begin
                x_q[i]    <= x_n[i];
                kind_q[i] <= kind_n[i];
            end
            lfsr_q    <= lfsr_n;
            level_q   <= level_n;
            cnt_q     <= cnt_n;
            pause_d_q <= bus.i_pause;
            if (bus.i_pause && !pause_d_q)
                paused_q <= ~paused_q;
            bus.o_x_l         <= x_l_c;
            bus.o_x_r         <= x_r_c;
            bus.o_y_t         <= y_t_c;
            bus.o_y_b         <= y_b_c;
            bus.o_active      <= active_c;
            bus.o_score       <= score_c;
            bus.o_level_up    <= level_up_c;
            bus.o_field_empty <= bus.i_done & all_empty_c;
        end
    end

    assign bus.o_level  = level_q;
    assign bus.o_paused = paused_q;
endmodule

// File: doc/obstacle_field_gen.md
Name: obstacle_field_gen

Overview:
Parametrised obstacle field generator for the side-scrolling runner game.
- Manages N_OBS obstacle slots that scroll left at a selectable speed.
- Recycles each slot off the left edge to the right, with an LFSR-chosen obstacle type.
- Emits score and level events, and drives packed per-slot rectangle bounds to the VGA draw and collision logic.

Parameters:
N_OBS, 8, number of obstacle slots
CW, 12, coordinate width
D_WIDTH, 640, display width in pixels
D_HEIGHT, 480, display height in pixels
H_WIDTH, 20, obstacle half-width
HEIGHT_L, 40, low obstacle height (floor-anchored)
HEIGHT_H, 400, high obstacle bottom edge (ceiling-anchored)
SPACING, 80, centre-to-centre slot pitch; must be >15
OBS_PER_LEVEL, 16, recycled non-empty obstacles per level
LFSR_SEED, 8'hA5, non-zero reset seed

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_ani_stb  in  1  one-cycle animation strobe
i_animate  in  1  motion enable
i_pause  in  1  pause button (level)
i_lose  in  1  freeze field when high
i_done  in  1  stop spawning; recycled slots become empty
i_speed  in  4  pixels moved per strobe
o_x_l  out  N_OBS*CW  packed left edges (slot i at [i*CW +: CW])
o_x_r  out  N_OBS*CW  packed right edges
o_y_t  out  N_OBS*CW  packed top edges
o_y_b  out  N_OBS*CW  packed bottom edges
o_active  out  N_OBS  slot holds a visible obstacle
o_score  out  1  one-cycle pulse per scored obstacle
o_level  out  8  current level
o_level_up  out  1  one-cycle pulse on level increment
o_paused  out  1  pause state
o_field_empty  out  1  i_done high and all slots empty

Behaviour:
- Per-slot state:
  - x[i]: virtual centre, CW bits; screen x = x - D_WIDTH.
  - kind[i]: 2 bits; 00 empty, 01 low, 10 high, 11 low.
- Reset, which overrides everything:
  - x[i] = 2*D_WIDTH + H_WIDTH + i*SPACING; kind = 01.
  - level = 1; recycle count = 0; LFSR = LFSR_SEED; paused = 0.
  - o_score = 0, o_level_up = 0, o_field_empty = 0.
  - All outputs take the hidden encoding.
- Pause:
  - A rising edge on i_pause (registered edge detect) toggles paused.
  - The toggle takes effect next cycle; a strobe in the same cycle uses the old state.
- A move cycle requires all of: i_ani_stb, i_animate, ~paused, ~i_lose. i_speed = 0 means no motion.
- Per slot, on each move cycle:
  - If x[i] <= D_WIDTH - H_WIDTH, the slot recycles:
    - x[i] += N_OBS*SPACING.
    - New kind = 00 if i_done, else LFSR[1:0].
    - LFSR (x^8+x^6+x^5+x^4+1, Fibonacci) advances once per recycle.
  - Otherwise x[i] -= speed.
- Scoring and levels:
  - With SPACING > 15, at most one slot recycles per move cycle; if more than one does, the lowest index drives the counters.
  - Recycling a slot whose old kind != 00 pulses o_score and increments the count.
  - When the count reaches OBS_PER_LEVEL: count clears, level increments (saturating at 255), o_level_up pulses in the same cycle as o_score.
- Outputs are registered, one cycle after the state update.
  - Visible slot: x_l = (x <= D_WIDTH + H_WIDTH) ? 0 : x - D_WIDTH - H_WIDTH; x_r = min(x + H_WIDTH - D_WIDTH, D_WIDTH), or 0 if x <= D_WIDTH - H_WIDTH.
  - Low: y_t = D_HEIGHT - HEIGHT_L, y_b = D_HEIGHT.
  - High: y_t = 0, y_b = HEIGHT_H.
  - Empty, or x_l >= D_WIDTH (off right): hidden encoding x_l = D_WIDTH, x_r = 0, y_t = D_HEIGHT, y_b = 0; o_active = 0.
- o_field_empty is registered: i_done & (all kinds == 00).
- i_rst mid-recycle discards the pending score and level pulses.

Optional Feature:
LEVEL_SPEEDUP_EN
- Defined: effective speed = min(i_speed + ((level - 1) >> 2), 15).
- Undefined: effective speed = i_speed.

Test Plan:
- Reset, then idle 5 cycles -> x[0] = 1300, x[7] = 1860; all o_active = 0; o_level = 1; o_score = 0.
- i_speed = 4, 170 move strobes -> slot 0 x = 620, o_x_l[0] = 0, o_x_r[0] = 0; next strobe recycles it to 1260 with one o_score pulse if its old kind != 00.
- Run until 16 non-empty recycles -> o_level = 2; o_level_up and o_score high in the same cycle; count cleared.
- Press i_pause, apply 10 strobes -> positions unchanged, o_paused = 1; press again -> motion resumes on the next strobe.
- Hold i_done -> every recycled slot gets kind 00; after N_OBS recycles o_field_empty = 1 and no further o_score pulses.
- i_lose high with strobes -> positions frozen; assert i_rst at the same time as a recycle -> reset values, no o_score pulse.
